// File: rtl/ghost_mode_pkg.sv
// Shared types and the per-level scatter/chase timetable for the ghost mode scheduler.
package ghost_mode_pkg;

   typedef enum logic [1:0] {
      MODE_SCATTER = 2'd0,
      MODE_CHASE   = 2'd1,
      MODE_FRIGHT  = 2'd2
   } ghost_mode_t;

   localparam int NUM_PHASES = 8;

   // Last entry is never used to advance; it only sets where the counter saturates (19).
   localparam logic [4:0] PHASE_TICKS [NUM_PHASES] = '{
      5'd7, 5'd20, 5'd7, 5'd20, 5'd5, 5'd20, 5'd5, 5'd20
   };

   function automatic ghost_mode_t phase_mode(input logic [2:0] idx);
      return idx[0] ? MODE_CHASE : MODE_SCATTER;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_CYCLES enabled cycles.
module tick_prescaler #(
   parameter int TICK_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Disabled cycles hold the count so a frozen schedule resumes mid-tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost behaviour-mode scheduler: scatter/chase timetable, fright requests and reverse pulses.
module ghost_mode_ctrl
   import ghost_mode_pkg::*;
#(
   parameter int CLOCK_FREQ_HZ = 25_000_000,
   parameter int TICK_CYCLES   = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       level_start,
   input  logic       pause,
   input  logic       pellet_eaten,
   input  logic       frightened,
   output logic       fright_start,
   output logic [1:0] mode,
   output logic       reverse,
   output logic [2:0] phase_idx
);

   if (CLOCK_FREQ_HZ < 1 || TICK_CYCLES < 1) begin : g_param_check
      $error("ghost_mode_ctrl: CLOCK_FREQ_HZ and TICK_CYCLES must be positive");
   end

   logic        run;
   logic        tick;
   logic        fright_q;
   logic        advance;
   logic [4:0]  sec_cnt;
   logic [4:0]  cnt_next;
   logic [2:0]  phase_next;
   logic        rev_next;
   ghost_mode_t mode_q;
   ghost_mode_t mode_next;

   assign run  = !pause && !frightened;
   assign mode = mode_q;

   tick_prescaler #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (run),
      .clr  (level_start),
      .tick (tick)
   );

   always_comb begin
      phase_next = phase_idx;
      cnt_next   = sec_cnt;
      advance    = 1'b0;
      if (tick) begin
         if (sec_cnt == 5'(PHASE_TICKS[phase_idx] - 5'd1)) begin
            if (phase_idx != 3'(NUM_PHASES - 1)) begin
               advance    = 1'b1;
               phase_next = phase_idx + 3'd1;
               cnt_next   = 5'd0;
            end
         end else begin
            cnt_next = sec_cnt + 5'd1;
         end
      end
      rev_next = advance || (frightened && !fright_q) || (pellet_eaten && fright_q);
      // A new level swallows any reverse cause arriving in the same cycle.
      if (level_start) begin
         phase_next = 3'd0;
         cnt_next   = 5'd0;
         rev_next   = 1'b0;
      end
      mode_next = frightened ? MODE_FRIGHT : phase_mode(phase_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_idx    <= 3'd0;
         sec_cnt      <= 5'd0;
         fright_q     <= 1'b0;
         fright_start <= 1'b0;
         reverse      <= 1'b0;
         mode_q       <= MODE_SCATTER;
      end else begin
         phase_idx    <= phase_next;
         sec_cnt      <= cnt_next;
         fright_q     <= frightened;
         fright_start <= fright_start ^ pellet_eaten;
         reverse      <= rev_next;
         mode_q       <= mode_next;
      end
   end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Self-checking bench for ghost_mode_ctrl with a behavioural strobe_gen stand-in.
module tb_ghost_mode_ctrl;

   localparam int TICK = 4;
   localparam int FRIGHT_CYCLES = 8;
   localparam int TBL [8] = '{7, 20, 7, 20, 5, 20, 5, 0};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       level_start;
   logic       pause;
   logic       pellet_eaten;
   logic       frightened;
   logic       fright_start;
   logic [1:0] mode;
   logic       reverse;
   logic [2:0] phase_idx;

   int total = 0;
   int bad = 0;

   ghost_mode_ctrl #(
      .CLOCK_FREQ_HZ(8),
      .TICK_CYCLES  (TICK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .level_start (level_start),
      .pause       (pause),
      .pellet_eaten(pellet_eaten),
      .frightened  (frightened),
      .fright_start(fright_start),
      .mode        (mode),
      .reverse     (reverse),
      .phase_idx   (phase_idx)
   );

   initial forever #5 clk = ~clk;

   // strobe_gen stand-in: any change on start (re)loads an 8-cycle strobe one cycle later.
   logic       start_q;
   logic [3:0] fcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         fcnt    <= 4'd0;
      end else begin
         start_q <= fright_start;
         if (fright_start != start_q) fcnt <= 4'(FRIGHT_CYCLES);
         else if (fcnt != 4'd0)       fcnt <= fcnt - 4'd1;
      end
   end
   assign frightened = (fcnt != 4'd0);

   // Reference model: phase derived from total run cycles elapsed since the level began.
   function automatic int phase_of(input int e);
      int cum = 0;
      for (int k = 0; k < 7; k++) begin
         cum += TBL[k] * TICK;
         if (e < cum) return k;
      end
      return 7;
   endfunction

   int         m_elapsed;
   logic       m_rev;
   logic [1:0] m_mode;
   logic       m_fs;
   logic       m_fq;
   logic       run_in;
   int         m_phase;
   assign run_in  = !pause && !frightened;
   assign m_phase = phase_of(m_elapsed);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_elapsed <= 0;
         m_rev     <= 1'b0;
         m_mode    <= 2'd0;
         m_fs      <= 1'b0;
         m_fq      <= 1'b0;
      end else begin
         m_fs <= m_fs ^ pellet_eaten;
         m_fq <= frightened;
         if (level_start) begin
            m_elapsed <= 0;
            m_rev     <= 1'b0;
            m_mode    <= frightened ? 2'd2 : 2'd0;
         end else begin
            m_elapsed <= m_elapsed + (run_in ? 1 : 0);
            m_rev <= (phase_of(m_elapsed + (run_in ? 1 : 0)) != phase_of(m_elapsed))
                     || (frightened && !m_fq) || (pellet_eaten && m_fq);
            m_mode <= frightened ? 2'd2 : 2'(phase_of(m_elapsed + (run_in ? 1 : 0)) % 2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_level_start();
      level_start = 1'b1;
      step();
      level_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; level_start = 1'b0; pause = 1'b0; pellet_eaten = 1'b0;
      step(); step(); step();
      total++; if (mode !== 2'd0)        begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
      total++; if (reverse !== 1'b0)     begin bad++; $display("FAIL reset_reverse got=%0b want=0", reverse); end
      total++; if (fright_start !== 1'b0) begin bad++; $display("FAIL reset_fright_start got=%0b want=0", fright_start); end
      total++; if (phase_idx !== 3'd0)   begin bad++; $display("FAIL reset_phase got=%0d want=0", phase_idx); end
      rst_n = 1'b1;
   endtask

   task automatic test_phase_advance();
      for (int c = 0; c <= 108; c++) begin
         if (c < 28) begin
            total++;
            if (mode !== 2'd0 || phase_idx !== 3'd0 || reverse !== 1'b0) begin
               bad++; $display("FAIL adv_scatter c=%0d got mode=%0d ph=%0d rev=%0b want 0/0/0", c, mode, phase_idx, reverse);
            end
         end
         if (c == 28) begin
            total++;
            if (mode !== 2'd1 || phase_idx !== 3'd1 || reverse !== 1'b1) begin
               bad++; $display("FAIL adv_to_1 got mode=%0d ph=%0d rev=%0b want 1/1/1", mode, phase_idx, reverse);
            end
         end
         if (c == 29) begin
            total++; if (reverse !== 1'b0) begin bad++; $display("FAIL adv_rev_width got=%0b want=0", reverse); end
         end
         if (c == 107) begin
            total++; if (phase_idx !== 3'd1) begin bad++; $display("FAIL adv_hold_1 got=%0d want=1", phase_idx); end
         end
         if (c == 108) begin
            total++;
            if (phase_idx !== 3'd2 || mode !== 2'd0 || reverse !== 1'b1) begin
               bad++; $display("FAIL adv_to_2 got ph=%0d mode=%0d rev=%0b want 2/0/1", phase_idx, mode, reverse);
            end
         end
         step();
      end
   endtask

   task automatic test_full_timetable();
      for (int c = 109; c <= 356; c++) begin
         if (c == 335) begin
            total++; if (phase_idx !== 3'd6) begin bad++; $display("FAIL tt_phase6 got=%0d want=6", phase_idx); end
         end
         if (c == 336) begin
            total++;
            if (phase_idx !== 3'd7 || reverse !== 1'b1) begin
               bad++; $display("FAIL tt_enter7 got ph=%0d rev=%0b want 7/1", phase_idx, reverse);
            end
         end
         if (c == 356) begin
            total++;
            if (phase_idx !== 3'd7 || mode !== 2'd1) begin
               bad++; $display("FAIL tt_final got ph=%0d mode=%0d want 7/1", phase_idx, mode);
            end
         end
         step();
      end
      for (int c = 0; c < 1000; c++) begin
         total++;
         if (reverse !== 1'b0 || phase_idx !== 3'd7 || mode !== 2'd1) begin
            bad++; $display("FAIL tt_forever c=%0d got rev=%0b ph=%0d mode=%0d want 0/7/1", c, reverse, phase_idx, mode);
         end
         step();
      end
   endtask

   task automatic test_fright();
      logic fs0;
      pulse_level_start();
      fs0 = m_fs;
      for (int c = 0; c <= 40; c++) begin
         if (c == 10) begin
            total++; if (fright_start !== fs0) begin bad++; $display("FAIL fr_start_early got=%0b want=%0b", fright_start, fs0); end
         end
         if (c == 11) begin
            total++; if (fright_start !== ~fs0) begin bad++; $display("FAIL fr_start_toggle got=%0b want=%0b", fright_start, ~fs0); end
         end
         if (c == 13) begin
            total++;
            if (mode !== 2'd2 || reverse !== 1'b1) begin
               bad++; $display("FAIL fr_enter got mode=%0d rev=%0b want 2/1", mode, reverse);
            end
         end
         if (c > 13 && c <= 20) begin
            total++;
            if (mode !== 2'd2 || reverse !== 1'b0) begin
               bad++; $display("FAIL fr_hold c=%0d got mode=%0d rev=%0b want 2/0", c, mode, reverse);
            end
         end
         if (c >= 21 && c <= 35) begin
            total++;
            if (mode !== 2'd0 || reverse !== 1'b0 || phase_idx !== 3'd0) begin
               bad++; $display("FAIL fr_resume c=%0d got mode=%0d rev=%0b ph=%0d want 0/0/0", c, mode, reverse, phase_idx);
            end
         end
         if (c == 36) begin
            total++;
            if (phase_idx !== 3'd1 || reverse !== 1'b1 || mode !== 2'd1) begin
               bad++; $display("FAIL fr_late_adv got ph=%0d rev=%0b mode=%0d want 1/1/1", phase_idx, reverse, mode);
            end
         end
         pellet_eaten = (c == 10);
         step();
      end
      pellet_eaten = 1'b0;
   endtask

   task automatic test_re_pellet();
      logic fs0;
      int   revs;
      pulse_level_start();
      fs0  = m_fs;
      revs = 0;
      for (int c = 0; c <= 20; c++) begin
         if (reverse === 1'b1) revs++;
         if (c >= 5 && c <= 18) begin
            total++; if (mode !== 2'd2) begin bad++; $display("FAIL rp_mode c=%0d got=%0d want=2", c, mode); end
         end
         if (c == 9) begin
            total++;
            if (reverse !== 1'b1 || fright_start !== fs0) begin
               bad++; $display("FAIL rp_second got rev=%0b fs=%0b want 1/%0b", reverse, fright_start, fs0);
            end
         end
         if (c == 19) begin
            total++; if (mode !== 2'd0) begin bad++; $display("FAIL rp_exit got=%0d want=0", mode); end
         end
         pellet_eaten = (c == 2 || c == 8);
         step();
      end
      pellet_eaten = 1'b0;
      total++; if (revs != 2) begin bad++; $display("FAIL rp_rev_count got=%0d want=2", revs); end
   endtask

   task automatic test_pause_restart();
      int guard;
      pulse_level_start();
      for (int c = 0; c < 40; c++) step();
      pause = 1'b1;
      for (int c = 0; c < 50; c++) begin
         step();
         total++;
         if (phase_idx !== 3'd1 || mode !== 2'd1 || reverse !== 1'b0) begin
            bad++; $display("FAIL ps_frozen c=%0d got ph=%0d mode=%0d rev=%0b want 1/1/0", c, phase_idx, mode, reverse);
         end
      end
      pause = 1'b0;
      guard = 0;
      while (m_elapsed != 107 && guard < 200) begin
         step();
         guard++;
      end
      total++;
      if (guard >= 200 || phase_idx !== 3'd1) begin
         bad++; $display("FAIL ps_reach_edge guard=%0d ph=%0d want ph=1 within 200", guard, phase_idx);
      end
      pulse_level_start();
      total++;
      if (phase_idx !== 3'd0 || mode !== 2'd0 || reverse !== 1'b0) begin
         bad++; $display("FAIL ps_level_start got ph=%0d mode=%0d rev=%0b want 0/0/0", phase_idx, mode, reverse);
      end
      step();
      total++; if (reverse !== 1'b0) begin bad++; $display("FAIL ps_no_late_rev got=%0b want=0", reverse); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         total++;
         if (mode !== m_mode || reverse !== m_rev || phase_idx !== 3'(m_phase) || fright_start !== m_fs) begin
            bad++;
            $display("FAIL rnd c=%0d got mode=%0d rev=%0b ph=%0d fs=%0b want %0d/%0b/%0d/%0b",
                     c, mode, reverse, phase_idx, fright_start, m_mode, m_rev, m_phase, m_fs);
         end
         pellet_eaten = ($urandom_range(0, 39) == 0);
         level_start  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 59) == 0) pause = ~pause;
         step();
      end
      pellet_eaten = 1'b0; level_start = 1'b0; pause = 1'b0;
   endtask

   task automatic test_async_reset();
      int guard;
      pulse_level_start();
      if (m_fs == 1'b0) begin
         pellet_eaten = 1'b1;
         step();
         pellet_eaten = 1'b0;
      end
      guard = 0;
      while (m_phase != 3 && guard < 400) begin
         step();
         guard++;
      end
      for (int c = 0; c < 10; c++) step();
      total++;
      if (guard >= 400 || phase_idx !== 3'd3 || fright_start !== 1'b1) begin
         bad++; $display("FAIL ar_setup guard=%0d ph=%0d fs=%0b want ph=3 fs=1", guard, phase_idx, fright_start);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (mode !== 2'd0 || reverse !== 1'b0 || fright_start !== 1'b0 || phase_idx !== 3'd0) begin
         bad++; $display("FAIL ar_immediate got mode=%0d rev=%0b fs=%0b ph=%0d want 0/0/0/0", mode, reverse, fright_start, phase_idx);
      end
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_phase_advance();
      test_full_timetable();
      test_fright();
      test_re_pellet();
      test_pause_restart();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
